icache_nway: RTL
================

// Module: icache_nway
// PURPOSE
//  Parametrised fully-associative instruction cache between the CPU fetch unit and the memory controller.
//  LINENUM ways, each holding one line of 2**LINEWORDBITS words.
//  Misses are filled by mem_burstlen-word bursts. The victim is the invalid way, else the oldest way by TTL.
//  New over the fixed 4-way block: any way count, any line length, a valid bit per way, a cache-wide invalidate,
//  and a registered single-request miss path with no queue.
// PARAMETERS
//  DATABITS      32  instruction word width
//  ADDRBITS      32  byte address width
//  LINEWORDBITS  5   log2 of words per line (LINEWORDS = 2**LINEWORDBITS)
//  LINENUM       4   number of ways, >=2
//  TTLBITS       8   width of per-way age counter, saturating
// PORTS
//  clk               in   1         system clock, all logic on rising edge
//  reset             in   1         synchronous, active-high reset
//  icache_addr       in   ADDRBITS  fetch byte address; bits [1:0] ignored
//  icache_rdreq      in   1         fetch request, sampled only while icache_ready=1
//  icache_invalidate in   1         single-cycle pulse: drop all lines
//  icache_ready      out  1         cache accepts a request this cycle
//  icache_out        out  DATABITS  fetched word
//  icache_out_valid  out  1         one-cycle strobe qualifying icache_out
//  mem_addr          out  ADDRBITS  burst start byte address
//  mem_rdreq         out  1         one-cycle burst request
//  mem_out           in   DATABITS  read data from memory
//  mem_out_valid     in   1         read data strobe
//  mem_burstlen      in   16        words per burst; 0 treated as 1
// BEHAVIOUR
//  Reset values: icache_ready=1, icache_out_valid=0, icache_out=0, mem_rdreq=0, mem_addr=0.
//  Reset also clears all way valid bits and ages, and puts the FSM in IDLE. Reset mid-fill aborts the fill.
//  Address split: word = addr[LINEWORDBITS+1:2], tag = addr[ADDRBITS-1:LINEWORDBITS+2].
//  Hit: a way is valid and its tag matches (at most one way can match).
//   - icache_out/icache_out_valid are registered one cycle after the request; icache_ready stays 1.
//   - Back-to-back hits give one word per cycle.
//  Ages (accepted request only): hit way -> 0; every other valid way increments, saturating at 2**TTLBITS-1.
//  Miss: registered request latched; icache_ready drops to 0 on the next cycle.
//  Victim: lowest-index invalid way; else the way with the largest age, ties to the lowest index.
//  FSM states: IDLE -> REQ -> FILL (-> DRAIN) -> DELIVER -> IDLE.
//  - IDLE: serve hits. On a miss, choose the victim, clear its valid bit, go to REQ.
//  - REQ: mem_rdreq=1 for one cycle. mem_addr = line base + 4*words_filled. Burst counter loads mem_burstlen.
//  - FILL: each mem_out_valid writes mem_out to victim[words_filled], then words_filled++ and burst count--.
//    - Burst count 0 with line incomplete -> REQ.
//    - Line complete with burst count 0 -> DELIVER. Line complete with burst count >0 -> DRAIN.
//  - DRAIN: discard mem_out_valid words until the burst count reaches 0, then DELIVER.
//    This keeps the memory controller in step when mem_burstlen does not divide LINEWORDS.
//  - DELIVER: set victim tag and valid, age 0. Drive the latched word with icache_out_valid=1.
//    icache_ready returns to 1 on the next cycle (IDLE).
//  mem_out_valid outside FILL/DRAIN is ignored.
//  icache_invalidate:
//   - In IDLE: all valid bits clear next cycle. A request in the same cycle is treated as a miss.
//   - In any other state: latched and applied on the DELIVER->IDLE edge, so the just-filled line is also dropped.
//  Miss penalty, fixed-latency memory L and burst B:
//   ceil(LINEWORDS/B) * (1 + L + B) + 2 cycles from request to icache_out_valid.
// STRUCTURE
//  icache_pkg: FSM state enum (IDLE, REQ, FILL, DRAIN, DELIVER); LINEWORDS, tag-width and index-width localparams.
//  Sub-module icache_way (one per way, generate loop):
//   - data RAM, tag, valid bit, saturating age counter.
//   - hit compare output; write port driven by the fill controller.
//  icache_nway holds the victim selector (priority/compare tree over LINENUM ages), the FSM,
//  the word/burst counters and the output mux.
// TESTING
//  1. Reset, then rdreq 0x100 with mem_burstlen=8, 4-cycle memory ->
//     4 mem_rdreq at 0x100, 0x120, 0x140, 0x160; icache_out = mem word 0; icache_ready back to 1.
//  2. After 1, rdreq 0x104, 0x108, 0x17C back-to-back -> three out_valid strobes on consecutive cycles;
//     no mem_rdreq.
//  3. LINENUM=4: fill lines 0x000, 0x080, 0x100, 0x180; hit 0x000 and 0x100; miss 0x200 ->
//     victim is the way holding 0x080 (oldest); 0x000 still hits afterwards.
//  4. mem_burstlen=0 -> 32 single-word bursts. mem_burstlen=24 -> second burst drains 16 extra words;
//     the next miss issues mem_rdreq correctly.
//  5. Invalidate in IDLE after 1 -> rdreq 0x100 misses again.
//     Invalidate pulsed during FILL -> the pending word is still delivered, then that line misses.
//  6. Reset asserted mid-FILL -> next cycle mem_rdreq=0, icache_ready=1, all ways invalid;
//     stale mem_out_valid words ignored.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and default geometry for the n-way instruction cache.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package icache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_FILL,
        ST_DRAIN,
        ST_DELIVER
    } state_e;

    localparam int DEF_DATABITS     = 32;
    localparam int DEF_ADDRBITS     = 32;
    localparam int DEF_LINEWORDBITS = 5;
    localparam int DEF_LINENUM      = 4;
    localparam int DEF_TTLBITS      = 8;
    localparam int DEF_LINEWORDS    = 1 << DEF_LINEWORDBITS;
    localparam int DEF_TAGBITS      = DEF_ADDRBITS - DEF_LINEWORDBITS - 2;
    localparam int DEF_IDXBITS      = $clog2(DEF_LINENUM);

    // A zero burst length still moves one word per request.
    function automatic logic [15:0] burst_load(input logic [15:0] len);
        return (len == 16'd0) ? 16'd1 : len;
    endfunction

endpackage

// File: rtl/icache_nway_if.sv
// Fetch-side and memory-side signal bundle of the instruction cache.
// Latency: n/a (wiring only).
// Backpressure: icache_ready gates fetch requests; memory side is strobe-driven.
interface icache_nway_if #(
    parameter int DATABITS = 32,
    parameter int ADDRBITS = 32
);
    logic [ADDRBITS-1:0] icache_addr;
    logic                icache_rdreq;
    logic                icache_invalidate;
    logic                icache_ready;
    logic [DATABITS-1:0] icache_out;
    logic                icache_out_valid;
    logic [ADDRBITS-1:0] mem_addr;
    logic                mem_rdreq;
    logic [DATABITS-1:0] mem_out;
    logic                mem_out_valid;
    logic [15:0]         mem_burstlen;

    // Fetch unit plus memory controller side.
    modport master (
        output icache_addr, icache_rdreq, icache_invalidate,
        input  icache_ready, icache_out, icache_out_valid,
        input  mem_addr, mem_rdreq,
        output mem_out, mem_out_valid, mem_burstlen
    );

    // Cache side.
    modport slave (
        input  icache_addr, icache_rdreq, icache_invalidate,
        output icache_ready, icache_out, icache_out_valid,
        output mem_addr, mem_rdreq,
        input  mem_out, mem_out_valid, mem_burstlen
    );
endinterface

// File: rtl/icache_way.sv
// One cache way: line data RAM, tag, valid bit and saturating age counter.
// Latency: hit and read data are combinational from the stored state.
// Backpressure: none; controlled entirely by the parent's fill controller.
module icache_way
    import icache_pkg::*;
#(
    parameter int DATABITS     = DEF_DATABITS,
    parameter int LINEWORDBITS = DEF_LINEWORDBITS,
    parameter int TAGBITS      = DEF_TAGBITS,
    parameter int TTLBITS      = DEF_TTLBITS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [TAGBITS-1:0]      lookup_tag,
    output logic                    hit,
    input  logic [LINEWORDBITS-1:0] rd_word,
    output logic [DATABITS-1:0]     rd_data,
    input  logic                    wr_en,
    input  logic [LINEWORDBITS-1:0] wr_word,
    input  logic [DATABITS-1:0]     wr_data,
    input  logic                    set_line,
    input  logic [TAGBITS-1:0]      set_tag,
    input  logic                    clr_valid,
    input  logic                    age_inc,
    input  logic                    age_clr,
    output logic                    valid,
    output logic [TTLBITS-1:0]      age
);
    localparam int LINEWORDS = 1 << LINEWORDBITS;

    logic [DATABITS-1:0] data_mem [LINEWORDS];
    logic [TAGBITS-1:0]  tag_q, tag_d;
    logic                valid_q, valid_d;
    logic [TTLBITS-1:0]  age_q, age_d;

    assign hit     = valid_q && (tag_q == lookup_tag);
    assign rd_data = data_mem[rd_word];
    assign valid   = valid_q;
    assign age     = age_q;

    // Line data is written only by the fill controller; valid bit guards stale contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[wr_word] <= wr_data;
        end
    end

    // Next tag/valid/age; a clear always beats a line install.
    always_comb begin
        tag_d   = tag_q;
        valid_d = valid_q;
        age_d   = age_q;
        if (set_line) begin
            tag_d   = set_tag;
            valid_d = 1'b1;
            age_d   = '0;
        end else if (age_clr) begin
            age_d = '0;
        end else if (age_inc && (age_q != {TTLBITS{1'b1}})) begin
            age_d = age_q + 1'b1;
        end
        if (clr_valid) begin
            valid_d = 1'b0;
        end
    end

    // Way state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_q   <= '0;
            valid_q <= 1'b0;
            age_q   <= '0;
        end else begin
            tag_q   <= tag_d;
            valid_q <= valid_d;
            age_q   <= age_d;
        end
    end

endmodule

// File: rtl/icache_nway.sv
// Fully-associative n-way instruction cache with burst line fill and age-based victim choice.
// Latency: hit one cycle after request; miss ready drops next cycle until the line is delivered.
// Backpressure: icache_ready low from the cycle after a miss until the cycle after delivery.
module icache_nway
    import icache_pkg::*;
#(
    parameter int DATABITS     = DEF_DATABITS,
    parameter int ADDRBITS     = DEF_ADDRBITS,
    parameter int LINEWORDBITS = DEF_LINEWORDBITS,
    parameter int LINENUM      = DEF_LINENUM,
    parameter int TTLBITS      = DEF_TTLBITS
) (
    input  logic         clk,
    input  logic         reset,
    icache_nway_if.slave bus
);
    localparam int LINEWORDS = 1 << LINEWORDBITS;
    localparam int TAGBITS   = ADDRBITS - LINEWORDBITS - 2;
    localparam int IDXBITS   = $clog2(LINENUM);
    localparam int WFBITS    = LINEWORDBITS + 1;

    logic [TAGBITS-1:0]      req_tag;
    logic [LINEWORDBITS-1:0] req_word;
    logic                    unused_addr_lsb;

    assign req_tag         = bus.icache_addr[ADDRBITS-1:LINEWORDBITS+2];
    assign req_word        = bus.icache_addr[LINEWORDBITS+1:2];
    assign unused_addr_lsb = ^bus.icache_addr[1:0];

    logic [LINENUM-1:0]  hit_vec;
    logic [LINENUM-1:0]  way_valid;
    logic [TTLBITS-1:0]  way_age  [LINENUM];
    logic [DATABITS-1:0] way_data [LINENUM];

    state_e                  state_q, state_d;
    logic                    ready_q, ready_d;
    logic [DATABITS-1:0]     out_q, out_d;
    logic                    out_valid_q, out_valid_d;
    logic                    mem_rdreq_q, mem_rdreq_d;
    logic [ADDRBITS-1:0]     mem_addr_q, mem_addr_d;
    logic [TAGBITS-1:0]      tag_q, tag_d;
    logic [LINEWORDBITS-1:0] word_q, word_d;
    logic [IDXBITS-1:0]      victim_q, victim_d;
    logic [WFBITS-1:0]       wf_q, wf_d, wf_next;
    logic [15:0]             bc_q, bc_d;
    logic                    inv_pend_q, inv_pend_d;

    logic               hit_any, hit_eff, accept, miss_clr, fill_wr, set_line, clr_all;
    logic [IDXBITS-1:0] hit_idx, vic_idx, inv_idx, old_idx;
    logic               inv_found;
    logic [TTLBITS-1:0] old_age;

    assign hit_eff = hit_any && !bus.icache_invalidate;

    for (genvar i = 0; i < LINENUM; i++) begin : g_way
        logic sel_hit;
        assign sel_hit = hit_eff && hit_vec[i];
        icache_way #(
            .DATABITS    (DATABITS),
            .LINEWORDBITS(LINEWORDBITS),
            .TAGBITS     (TAGBITS),
            .TTLBITS     (TTLBITS)
        ) u_way (
            .clk       (clk),
            .reset     (reset),
            .lookup_tag(req_tag),
            .hit       (hit_vec[i]),
            .rd_word   (req_word),
            .rd_data   (way_data[i]),
            .wr_en     (fill_wr && (victim_q == IDXBITS'(i))),
            .wr_word   (wf_q[LINEWORDBITS-1:0]),
            .wr_data   (bus.mem_out),
            .set_line  (set_line && (victim_q == IDXBITS'(i))),
            .set_tag   (tag_q),
            .clr_valid (clr_all || (miss_clr && (vic_idx == IDXBITS'(i)))),
            .age_inc   (accept && way_valid[i] && !sel_hit),
            .age_clr   (accept && sel_hit),
            .valid     (way_valid[i]),
            .age       (way_age[i])
        );
    end

    // Encode the (at most one) matching way.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < LINENUM; i++) begin
            if (hit_vec[i]) begin
                hit_any = 1'b1;
                hit_idx = IDXBITS'(i);
            end
        end
    end

    // Victim: lowest invalid way, else oldest way with ties going to the lower index.
    always_comb begin
        inv_found = 1'b0;
        inv_idx   = '0;
        old_idx   = '0;
        old_age   = way_age[0];
        for (int i = LINENUM - 1; i >= 0; i--) begin
            if (!way_valid[i]) begin
                inv_found = 1'b1;
                inv_idx   = IDXBITS'(i);
            end
        end
        for (int i = 1; i < LINENUM; i++) begin
            if (way_age[i] > old_age) begin
                old_age = way_age[i];
                old_idx = IDXBITS'(i);
            end
        end
        vic_idx = inv_found ? inv_idx : old_idx;
    end

    // Miss/fill controller; the requested word is captured into the output register as it streams past.
    always_comb begin
        state_d     = state_q;
        ready_d     = ready_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        mem_rdreq_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        tag_d       = tag_q;
        word_d      = word_q;
        victim_d    = victim_q;
        wf_d        = wf_q;
        wf_next     = wf_q + 1'b1;
        bc_d        = bc_q;
        inv_pend_d  = inv_pend_q;
        accept      = 1'b0;
        miss_clr    = 1'b0;
        fill_wr     = 1'b0;
        set_line    = 1'b0;
        clr_all     = 1'b0;
        if (bus.icache_invalidate && (state_q != ST_IDLE) && (state_q != ST_DELIVER)) begin
            inv_pend_d = 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                clr_all = bus.icache_invalidate;
                accept  = bus.icache_rdreq && ready_q;
                if (accept) begin
                    if (hit_eff) begin
                        out_d       = way_data[hit_idx];
                        out_valid_d = 1'b1;
                    end else begin
                        tag_d       = req_tag;
                        word_d      = req_word;
                        victim_d    = vic_idx;
                        miss_clr    = 1'b1;
                        wf_d        = '0;
                        mem_addr_d  = {req_tag, {LINEWORDBITS{1'b0}}, 2'b00};
                        mem_rdreq_d = 1'b1;
                        ready_d     = 1'b0;
                        state_d     = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                bc_d    = burst_load(bus.mem_burstlen);
                state_d = ST_FILL;
            end
            ST_FILL: begin
                if (bus.mem_out_valid) begin
                    fill_wr = 1'b1;
                    wf_d    = wf_next;
                    bc_d    = bc_q - 16'd1;
                    if (wf_q[LINEWORDBITS-1:0] == word_q) begin
                        out_d = bus.mem_out;
                    end
                    if (wf_q == WFBITS'(LINEWORDS - 1)) begin
                        if (bc_q == 16'd1) begin
                            out_valid_d = 1'b1;
                            state_d     = ST_DELIVER;
                        end else begin
                            state_d = ST_DRAIN;
                        end
                    end else if (bc_q == 16'd1) begin
                        mem_rdreq_d = 1'b1;
                        mem_addr_d  = {tag_q, wf_next[LINEWORDBITS-1:0], 2'b00};
                        state_d     = ST_REQ;
                    end
                end
            end
            ST_DRAIN: begin
                if (bus.mem_out_valid) begin
                    bc_d = bc_q - 16'd1;
                    if (bc_q == 16'd1) begin
                        out_valid_d = 1'b1;
                        state_d     = ST_DELIVER;
                    end
                end
            end
            ST_DELIVER: begin
                set_line   = 1'b1;
                clr_all    = inv_pend_q || bus.icache_invalidate;
                inv_pend_d = 1'b0;
                ready_d    = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // Controller registers; reset aborts any fill in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b1;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            mem_rdreq_q <= 1'b0;
            mem_addr_q  <= '0;
            tag_q       <= '0;
            word_q      <= '0;
            victim_q    <= '0;
            wf_q        <= '0;
            bc_q        <= '0;
            inv_pend_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            mem_rdreq_q <= mem_rdreq_d;
            mem_addr_q  <= mem_addr_d;
            tag_q       <= tag_d;
            word_q      <= word_d;
            victim_q    <= victim_d;
            wf_q        <= wf_d;
            bc_q        <= bc_d;
            inv_pend_q  <= inv_pend_d;
        end
    end

    assign bus.icache_ready     = ready_q;
    assign bus.icache_out       = out_q;
    assign bus.icache_out_valid = out_valid_q;
    assign bus.mem_rdreq        = mem_rdreq_q;
    assign bus.mem_addr         = mem_addr_q;

endmodule
